// File: rtl/tw_buf_seq.sv
// Twiddle-factor buffer and sequencer for the radix-16 NTT/FFT datapath.
// Storage holds STAGES x GROUPS x DEPTH entries of LANES twiddles each, plus
// one constant word per stage. Entries are filled from a DW-wide beat stream
// and replayed per stage with a configurable pass count and group rotation.
//
// Load handshake: a beat transfers on a rising CLK edge where ld_valid and
// ld_ready are both high. ld_ready is high only while the load FSM is in
// LOAD. A beat offered while ld_ready is low is not taken. The producer
// keeps ld_data stable while ld_valid is high and ld_ready is low.
module tw_buf_seq #(
  parameter int DW     = 64,
  parameter int LANES  = 2,
  parameter int STAGES = 4,
  parameter int GROUPS = 4,
  parameter int DEPTH  = 4,
  parameter int REP_W  = 5,
  localparam int P_WIDTH  = DW * LANES,
  localparam int SC_WIDTH = ((STAGES > 1) ? $clog2(STAGES) : 1) + 1,
  localparam int GW       = (GROUPS > 1) ? $clog2(GROUPS) : 1,
  localparam int GCW      = $clog2(GROUPS) + 1
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                rd_en,
  input  logic                step_en,
  input  logic [SC_WIDTH-1:0] stage_counter,
  input  logic [REP_W-1:0]    cfg_passes,
  input  logic [GCW-1:0]      cfg_groups,
  input  logic                ld_start,
  input  logic [SC_WIDTH-1:0] ld_stage,
  input  logic [GW-1:0]       ld_group,
  input  logic                ld_const,
  input  logic                ld_valid,
  input  logic [DW-1:0]       ld_data,
  output logic                ld_ready,
  output logic                ld_done,
  output logic [P_WIDTH-1:0]  Q,
  output logic                q_valid,
  output logic [P_WIDTH-1:0]  Q_const,
  output logic                ld_state_o
);

  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int EW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int NB = DEPTH * LANES;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW = SW + GW + EW;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOAD = 1'b1;

  localparam logic [P_WIDTH-1:0] IDENT = {LANES{DW'(1)}};

  // Load FSM state and latched load target
  logic [0:0]    state_q, state_d;
  logic [BW-1:0] b_q, b_d;
  logic [SW-1:0] tgt_stage_q, tgt_stage_d;
  logic [GW-1:0] tgt_group_q, tgt_group_d;
  logic          tgt_const_q, tgt_const_d;
  logic          done_q, done_d;

  // Read sequencer counters and stage tracking
  logic [EW-1:0]       e_q, e_d;
  logic [REP_W-1:0]    p_q, p_d;
  logic [GW-1:0]       g_q, g_d;
  logic [SC_WIDTH-1:0] stage_prev_q;

  logic          beat;
  logic          last_beat;
  logic          wr_en;
  logic [EW-1:0] wr_entry;
  logic [LW-1:0] wr_lane;
  logic [AW-1:0] wr_addr;

  logic [EW-1:0]      rd_e;
  logic [GW-1:0]      rd_g;
  logic [AW-1:0]      rd_addr;
  logic [SW-1:0]      rd_stage;
  logic               stage_ok;
  logic [P_WIDTH-1:0] rd_word;
  logic [P_WIDTH-1:0] cst_word;

  logic [REP_W-1:0] passes_m1;
  logic [GCW-1:0]   groups_eff;
  logic [GCW-1:0]   groups_m1;

  assign ld_ready   = (state_q == S_LOAD);
  assign ld_done    = done_q;
  assign ld_state_o = state_q;

  assign beat      = ld_valid && ld_ready;
  assign last_beat = (b_q == (tgt_const_q ? BW'(LANES - 1) : BW'(NB - 1)));
  // A beat presented on the reset edge is dropped along with the load.
  assign wr_en     = beat && !rst;
  // Beat b fills entry b/LANES, most significant lane first.
  assign wr_entry  = EW'(int'(b_q) / LANES);
  assign wr_lane   = LW'(LANES - 1 - (int'(b_q) % LANES));
  assign wr_addr   = {tgt_stage_q, tgt_group_q, wr_entry};

  assign rd_stage  = stage_counter[SW-1:0];
  assign rd_addr   = {rd_stage, rd_g, rd_e};
  assign stage_ok  = (stage_counter < SC_WIDTH'(STAGES));

  assign passes_m1 = ((cfg_passes == '0) ? REP_W'(1) : cfg_passes) - REP_W'(1);
  assign groups_eff = (cfg_groups == '0)           ? GCW'(1) :
                      (cfg_groups > GCW'(GROUPS))  ? GCW'(GROUPS) : cfg_groups;
  assign groups_m1 = groups_eff - GCW'(1);

  // Load FSM next-state: accept a start in IDLE, count beats in LOAD
  always_comb begin
    state_d     = state_q;
    b_d         = b_q;
    tgt_stage_d = tgt_stage_q;
    tgt_group_d = tgt_group_q;
    tgt_const_d = tgt_const_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ld_start && (ld_stage < SC_WIDTH'(STAGES))) begin
          tgt_stage_d = ld_stage[SW-1:0];
          tgt_group_d = ld_group;
          tgt_const_d = ld_const;
          b_d         = '0;
          state_d     = S_LOAD;
        end
      end
      default: begin
        if (beat) begin
          if (last_beat) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            b_d = b_q + 1'b1;
          end
        end
      end
    endcase
  end

  // Load FSM registers
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= S_IDLE;
      b_q         <= '0;
      tgt_stage_q <= '0;
      tgt_group_q <= '0;
      tgt_const_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      b_q         <= b_d;
      tgt_stage_q <= tgt_stage_d;
      tgt_group_q <= tgt_group_d;
      tgt_const_q <= tgt_const_d;
      done_q      <= done_d;
    end
  end

  // Sequencer next-state: restart on stage change, rewind e when not stepping
  always_comb begin
    e_d  = e_q;
    p_d  = p_q;
    g_d  = g_q;
    rd_e = e_q;
    rd_g = g_q;
    if (rd_en) begin
      if (stage_counter != stage_prev_q) begin
        e_d  = '0;
        p_d  = '0;
        g_d  = '0;
        rd_e = '0;
        rd_g = '0;
      end else if (!step_en) begin
        e_d = '0;
      end else if (e_q == EW'(DEPTH - 1)) begin
        e_d = '0;
        if (p_q >= passes_m1) begin
          p_d = '0;
          g_d = (GCW'(g_q) >= groups_m1) ? '0 : g_q + 1'b1;
        end else begin
          p_d = p_q + 1'b1;
        end
      end else begin
        e_d = e_q + 1'b1;
      end
    end
  end

  // Sequencer registers; stage tracking follows stage_counter every edge
  always_ff @(posedge CLK) begin
    if (rst) begin
      e_q          <= '0;
      p_q          <= '0;
      g_q          <= '0;
      stage_prev_q <= stage_counter;
    end else begin
      e_q          <= e_d;
      p_q          <= p_d;
      g_q          <= g_d;
      stage_prev_q <= stage_counter;
    end
  end

  // Per-lane storage; only the addressed lane is written by a beat
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] cst_q [2**SW];

    // Entry and constant storage write port (contents survive reset)
    always_ff @(posedge CLK) begin
      if (wr_en && !tgt_const_q && (wr_lane == LW'(k))) mem_q[wr_addr] <= ld_data;
      if (wr_en && tgt_const_q && (wr_lane == LW'(k))) cst_q[tgt_stage_q] <= ld_data;
    end

    assign rd_word[k*DW +: DW]  = mem_q[rd_addr];
    assign cst_word[k*DW +: DW] = cst_q[rd_stage];
  end

  // Registered outputs; reads see pre-write contents on a same-cycle write
  always_ff @(posedge CLK) begin
    if (rst) begin
      Q       <= '0;
      q_valid <= 1'b0;
      Q_const <= '0;
    end else if (rd_en && stage_ok) begin
      Q       <= rd_word;
      q_valid <= 1'b1;
      Q_const <= cst_word;
    end else begin
      Q       <= IDENT;
      q_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tw_buf_seq.sv
// Directed bench for tw_buf_seq: loads, replay order, stalls, stage changes,
// disabled/out-of-range reads and reset in the middle of a load.
module tb_tw_buf_seq;

  localparam int DW     = 64;
  localparam int LANES  = 2;
  localparam int STAGES = 4;
  localparam int GROUPS = 4;
  localparam int DEPTH  = 4;
  localparam int REP_W  = 5;
  localparam int PW     = DW * LANES;
  localparam int SCW    = 3;
  localparam int GW     = 2;
  localparam int GCW    = 3;
  localparam logic [PW-1:0] IDENT = {64'd1, 64'd1};

  // clock / reset
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic            rst;
  logic            rd_en;
  logic            step_en;
  logic [SCW-1:0]  stage_counter;
  logic [REP_W-1:0] cfg_passes;
  logic [GCW-1:0]  cfg_groups;
  logic            ld_start;
  logic [SCW-1:0]  ld_stage;
  logic [GW-1:0]   ld_group;
  logic            ld_const;
  logic            ld_valid;
  logic [DW-1:0]   ld_data;
  logic            ld_ready;
  logic            ld_done;
  logic [PW-1:0]   Q;
  logic            q_valid;
  logic [PW-1:0]   Q_const;
  logic            ld_state_o;

  tw_buf_seq dut (
    .CLK(CLK), .rst(rst), .rd_en(rd_en), .step_en(step_en),
    .stage_counter(stage_counter), .cfg_passes(cfg_passes), .cfg_groups(cfg_groups),
    .ld_start(ld_start), .ld_stage(ld_stage), .ld_group(ld_group), .ld_const(ld_const),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .ld_done(ld_done),
    .Q(Q), .q_valid(q_valid), .Q_const(Q_const), .ld_state_o(ld_state_o)
  );

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  // scoreboard model of storage and the expected read queue
  logic [DW-1:0] m_mem [STAGES][GROUPS][DEPTH][LANES];
  logic [DW-1:0] m_cst [STAGES][LANES];
  logic [PW-1:0] exp_q [$];

  always @(negedge CLK) if (ld_done === 1'b1) done_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [DW-1:0] bv(input logic [7:0] tag, input int s, input int g, input int i);
    return {tag, s[7:0], g[7:0], i[7:0], 32'hC0DE_0000 + i};
  endfunction

  function automatic logic [PW-1:0] m_entry(input int s, input int g, input int e);
    return {m_mem[s][g][e][1], m_mem[s][g][e][0]};
  endfunction

  function automatic logic [PW-1:0] m_const(input int s);
    return {m_cst[s][1], m_cst[s][0]};
  endfunction

  // driver: start a load and push nb beats; checks done only for complete loads
  task automatic load(input int s, input int g, input bit cst, input int nb, input logic [7:0] tag);
    int total;
    total = cst ? LANES : DEPTH * LANES;
    ld_start = 1'b1;
    ld_stage = s[SCW-1:0];
    ld_group = g[GW-1:0];
    ld_const = cst;
    tick();
    ld_start = 1'b0;
    chk("ld_ready_on", {127'd0, ld_ready}, 128'd1);
    for (int i = 0; i < nb; i++) begin
      ld_valid = 1'b1;
      ld_data  = bv(tag, s, g, i);
      if (cst) m_cst[s][LANES - 1 - (i % LANES)] = ld_data;
      else     m_mem[s][g][i / LANES][LANES - 1 - (i % LANES)] = ld_data;
      tick();
    end
    ld_valid = 1'b0;
    if (nb == total) begin
      chk("ld_done_pulse", {127'd0, ld_done}, 128'd1);
      chk("ld_ready_off", {127'd0, ld_ready}, 128'd0);
    end
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; step_en = 1'b0; stage_counter = '0;
    cfg_passes = '0; cfg_groups = '0; ld_start = 1'b0; ld_stage = '0;
    ld_group = '0; ld_const = 1'b0; ld_valid = 1'b0; ld_data = '0;
    tick();
    tick();
    chk("rst_Q", Q, 128'd0);
    chk("rst_q_valid", {127'd0, q_valid}, 128'd0);
    chk("rst_Q_const", Q_const, 128'd0);
    chk("rst_ld_ready", {127'd0, ld_ready}, 128'd0);
    chk("rst_ld_done", {127'd0, ld_done}, 128'd0);
    rst = 1'b0;

    // storage fill
    load(0, 0, 1'b0, 8, 8'hA1);
    load(0, 0, 1'b1, 2, 8'hC0);
    load(1, 0, 1'b0, 8, 8'hB0);
    load(1, 1, 1'b0, 8, 8'hB1);
    load(1, 2, 1'b0, 8, 8'hB2);
    load(1, 0, 1'b1, 2, 8'hC1);
    load(2, 0, 1'b0, 8, 8'hD0);
    load(2, 0, 1'b1, 2, 8'hC2);
    load(3, 0, 1'b0, 8, 8'hE0);
    tick();
    chk("done_count_9", 128'(done_cnt), 128'd9);

    // test 1: stage 0 replay; passes=0 and groups=0 both behave as 1
    stage_counter = 3'd0; rd_en = 1'b1; step_en = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (n == 0) begin
        chk("t1_hand_A0A1", Q, {bv(8'hA1, 0, 0, 0), bv(8'hA1, 0, 0, 1)});
        chk("t1_Q_const", Q_const, {bv(8'hC0, 0, 0, 0), bv(8'hC0, 0, 0, 1)});
      end
      if (n == 3) chk("t1_hand_A6A7", Q, {bv(8'hA1, 0, 0, 6), bv(8'hA1, 0, 0, 7)});
      chk("t1_Q", Q, m_entry(0, 0, n % 4));
      chk("t1_q_valid", {127'd0, q_valid}, 128'd1);
    end
    step_en = 1'b0;
    tick();
    rd_en = 1'b0; stage_counter = 3'd1;
    tick();

    // test 2: stage 1, two passes per group, three groups
    cfg_passes = 5'd2; cfg_groups = 3'd3; rd_en = 1'b1; step_en = 1'b1;
    for (int n = 0; n < 26; n++) exp_q.push_back(m_entry(1, (n / 8) % 3, n % 4));
    for (int n = 0; n < 26; n++) begin
      tick();
      chk("t2_Q", Q, exp_q.pop_front());
      if (n == 0) chk("t2_Q_const", Q_const, m_const(1));
    end

    // test 3: one-cycle step_en drop rewinds e, keeps p and g
    step_en = 1'b0;
    tick();
    chk("t3_stall_read", Q, m_entry(1, 0, 2));
    step_en = 1'b1;
    for (int n = 0; n < 9; n++) exp_q.push_back((n < 8) ? m_entry(1, 0, n % 4) : m_entry(1, 1, 0));
    for (int n = 0; n < 9; n++) begin
      tick();
      chk("t3_Q", Q, exp_q.pop_front());
    end

    // test 4: stage change mid-sequence
    stage_counter = 3'd2;
    tick();
    chk("t4_Q", Q, m_entry(2, 0, 0));
    chk("t4_Q_const", Q_const, m_const(2));
    chk("t4_q_valid", {127'd0, q_valid}, 128'd1);

    // test 5: read disabled, then stage out of range
    rd_en = 1'b0;
    tick();
    chk("t5_off_Q", Q, IDENT);
    chk("t5_off_q_valid", {127'd0, q_valid}, 128'd0);
    chk("t5_off_Q_const", Q_const, m_const(2));
    stage_counter = 3'd4; rd_en = 1'b1;
    tick();
    chk("t5_oor_Q", Q, IDENT);
    chk("t5_oor_q_valid", {127'd0, q_valid}, 128'd0);
    chk("t5_oor_Q_const", Q_const, m_const(2));

    // test 6: ignored out-of-range load, reset in the middle of a load
    rd_en = 1'b0;
    ld_start = 1'b1; ld_stage = 3'd4; ld_const = 1'b0;
    tick();
    ld_start = 1'b0;
    chk("t6_bad_stage_ready", {127'd0, ld_ready}, 128'd0);
    load(3, 0, 1'b0, 3, 8'hF3);
    rst = 1'b1;
    tick();
    chk("t6_rst_ld_ready", {127'd0, ld_ready}, 128'd0);
    chk("t6_rst_Q", Q, 128'd0);
    chk("t6_rst_q_valid", {127'd0, q_valid}, 128'd0);
    chk("t6_rst_Q_const", Q_const, 128'd0);
    chk("t6_rst_ld_done", {127'd0, ld_done}, 128'd0);
    rst = 1'b0;
    load(3, 0, 1'b1, 2, 8'hC3);
    tick();
    chk("t6_done_count", 128'(done_cnt), 128'd10);
    stage_counter = 3'd3;
    tick();
    rd_en = 1'b1; step_en = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("t6_Q", Q, m_entry(3, 0, n));
      if (n == 0) chk("t6_Q_const", Q_const, {bv(8'hC3, 3, 0, 0), bv(8'hC3, 3, 0, 1)});
      if (n == 1) chk("t6_hand_mixed", Q, {bv(8'hF3, 3, 0, 2), bv(8'hE0, 3, 0, 3)});
      if (n == 2) chk("t6_hand_old", Q, {bv(8'hE0, 3, 0, 4), bv(8'hE0, 3, 0, 5)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
